// File: rtl/hilo_mdu_if.sv
// Bus bundle between the pipeline and the HI/LO multiply/divide unit.
// The master drives requests and direct writes; the slave returns status and HI/LO read data.
interface hilo_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, hi_in, lo_in,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, hi_in, lo_in,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine.
// The engine takes WIDTH cycles per operation and pulses done for one cycle on writeback.
// A flush cancels an in-flight operation without touching HI/LO.
// Optional macro HILO_BYPASS_EN: forwards direct HI/LO writes combinationally to the read ports.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  hilo_mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  // Two's-complement negate when en is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r, neg_q_r, neg_r_r, div_zero_r;
  logic [WIDTH-1:0]   a_raw_r, opnd_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;

  logic               start_ok_s, wb_s, busy_nxt_s;
  logic               sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   a_abs_s, b_abs_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s;
  logic [WIDTH-1:0]   diff_s;
  logic               ge_s;
  logic [2*WIDTH-1:0] step_s, neg_prod_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  // A flush in IDLE swallows a simultaneous start.
  assign start_ok_s = (state_r == IDLE) && bus.start && !bus.flush;

  // Operand signs and magnitudes; MULTU/DIVU (op[0]=1) treat operands as unsigned.
  always_comb begin
    sign_a_s = !bus.op[0] && bus.src_a[WIDTH-1];
    sign_b_s = !bus.op[0] && bus.src_b[WIDTH-1];
    a_abs_s  = neg_if(bus.src_a, sign_a_s);
    b_abs_s  = neg_if(bus.src_b, sign_b_s);
  end

  // One iteration: shift-add for multiply, restore-or-subtract for divide.
  always_comb begin
    mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    rem_sh_s  = prod_r[2*WIDTH-1:WIDTH-1];
    ge_s      = rem_sh_s >= {1'b0, opnd_r};
    diff_s    = rem_sh_s[WIDTH-1:0] - opnd_r;
    if (is_div_r) begin
      step_s = ge_s ? {diff_s, prod_r[WIDTH-2:0], 1'b1}
                    : {rem_sh_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
    end else begin
      step_s = {mul_sum_s, prod_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step; min/-1 falls out naturally as quotient=min, remainder=0.
  always_comb begin
    neg_prod_s = ~step_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    if (!is_div_r) begin
      {res_hi_s, res_lo_s} = neg_q_r ? neg_prod_s : step_s;
    end else if (div_zero_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = neg_if(step_s[2*WIDTH-1:WIDTH], neg_r_r);
      res_lo_s = neg_if(step_s[WIDTH-1:0], neg_q_r);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush always returns CALC to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_nxt_s = CALC;
        else            state_nxt_s = IDLE;
      end
      CALC: begin
        if (bus.flush || (cnt_r == CNT_LAST)) state_nxt_s = IDLE;
        else                                  state_nxt_s = CALC;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: writeback on the last un-flushed CALC edge, busy follows next state.
  always_comb begin
    wb_s       = (state_r == CALC) && !bus.flush && (cnt_r == CNT_LAST);
    busy_nxt_s = (state_nxt_s == CALC);
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= wb_s;
    end
  end

  // Engine datapath: operand capture at start, one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      a_raw_r    <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      prod_r     <= {(2*WIDTH){1'b0}};
    end else if (start_ok_s) begin
      cnt_r      <= {CW{1'b0}};
      is_div_r   <= bus.op[1];
      neg_q_r    <= sign_a_s ^ sign_b_s;
      neg_r_r    <= sign_a_s;
      div_zero_r <= (bus.src_b == {WIDTH{1'b0}});
      a_raw_r    <= bus.src_a;
      opnd_r     <= bus.op[1] ? b_abs_s : a_abs_s;
      prod_r     <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs_s : b_abs_s)};
    end else if (state_r == CALC) begin
      cnt_r  <= cnt_r + CW'(1);
      prod_r <= step_s;
    end
  end

  // HI/LO registers; engine writeback overrides direct writes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (wb_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else begin
      if (bus.hi_we) hi_r <= bus.hi_in;
      if (bus.lo_we) lo_r <= bus.lo_in;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;

`ifdef HILO_BYPASS_EN
  assign bus.hi_out = bus.hi_we ? bus.hi_in : hi_r;
  assign bus.lo_out = bus.lo_we ? bus.lo_in : lo_r;
`else
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;
`endif
endmodule

// File: tb/tb_hilo_mdu.sv
// Directed testbench for hilo_mdu at WIDTH=32 with hand-computed expected values.
module tb_hilo_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hilo_mdu_if #(.WIDTH(W)) bus ();
  hilo_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue an operation in the current cycle (cycle 0) and check the full timeline.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      chk({tag, " busy"}, 64'(bus.busy), 64'd1);
      chk({tag, " done early"}, 64'(bus.done), 64'd0);
      tick;
    end
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " busy end"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi_out), 64'(eh));
    chk({tag, " lo"}, 64'(bus.lo_out), 64'(el));
    tick;
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.hi_in = 32'd0; bus.lo_in = 32'd0;
    tick;
    rst = 1'b0;

    // Reset with an operation in flight and busy traffic on the inputs.
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd5;
    tick;
    bus.start = 1'b0;
    tick; tick;
    chk("pre-reset busy", 64'(bus.busy), 64'd1);
    rst = 1'b1; bus.start = 1'b1; bus.hi_we = 1'b1; bus.hi_in = 32'hDEAD;
    tick; tick;
    rst = 1'b0; bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("rst hi", 64'(bus.hi_out), 64'd0);
    chk("rst lo", 64'(bus.lo_out), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    tick;
    chk("post-rst busy", 64'(bus.busy), 64'd0);
    chk("post-rst done", 64'(bus.done), 64'd0);

    // Multiplies and divides.
    run_op("MULT -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("MULT -2*-3", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6);
    run_op("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("DIVU 7/0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("DIV -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Flush mid-CALC leaves preloaded HI/LO alone.
    bus.hi_we = 1'b1; bus.hi_in = 32'h11; bus.lo_we = 1'b1; bus.lo_in = 32'h22;
    tick;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd5; bus.src_b = 32'd5;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    chk("flush busy c10", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("flush busy c11", 64'(bus.busy), 64'd0);
    chk("flush done c11", 64'(bus.done), 64'd0);
    chk("flush hi", 64'(bus.hi_out), 64'h11);
    chk("flush lo", 64'(bus.lo_out), 64'h22);
    for (int i = 0; i < W + 2; i++) begin
      tick;
      chk("flush no done", 64'(bus.done), 64'd0);
    end
    chk("flush hi later", 64'(bus.hi_out), 64'h11);
    chk("flush lo later", 64'(bus.lo_out), 64'h22);

    // Flush and start together in IDLE: the start is dropped.
    bus.start = 1'b1; bus.flush = 1'b1;
    tick;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush+start busy", 64'(bus.busy), 64'd0);

    // Collision: MTLO mid-CALC and MTHI in the writeback cycle both lose to the result.
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd2; bus.src_b = 32'd3;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i <= W; i++) begin
      bus.lo_we = (i == 5); bus.lo_in = 32'h55;
      bus.hi_we = (i == W); bus.hi_in = 32'hAAAA;
      // A start while in CALC must be ignored.
      bus.start = (i == 8); bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
      if (i == 6) chk("mtlo mid-calc", 64'(bus.lo_out), 64'h55);
      tick;
    end
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
    chk("collide done", 64'(bus.done), 64'd1);
    chk("collide hi", 64'(bus.hi_out), 64'h0);
    chk("collide lo", 64'(bus.lo_out), 64'd6);
    tick;
    chk("collide idle busy", 64'(bus.busy), 64'd0);

    // Direct-write read latency, with and without forwarding.
    bus.hi_we = 1'b1; bus.hi_in = 32'h1234;
    bus.lo_we = 1'b1; bus.lo_in = 32'h5678;
    #1;
`ifdef HILO_BYPASS_EN
    chk("mthi same cycle", 64'(bus.hi_out), 64'h1234);
    chk("mtlo same cycle", 64'(bus.lo_out), 64'h5678);
`else
    chk("mthi same cycle", 64'(bus.hi_out), 64'h0);
    chk("mtlo same cycle", 64'(bus.lo_out), 64'd6);
`endif
    tick;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mthi next cycle", 64'(bus.hi_out), 64'h1234);
    chk("mtlo next cycle", 64'(bus.lo_out), 64'h5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Parametrised HI/LO register pair with an integrated iterative multiply/divide engine. It sits in the EX/MEM boundary of the core. It serves MULT/MULTU/DIV/DIVU, which write HI and LO together after a fixed multi-cycle latency, and MTHI/MTLO, which write directly. It exposes a start/busy/done handshake so the pipeline can stall on MFHI/MFLO while an operation is in flight, and a flush input to cancel speculative operations.

## Interface
- WIDTH, 32, data width of operands, HI and LO (>= 4)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a mul/div; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- flush  in  1  abort in-flight operation
- hi_we  in  1  direct write HI (MTHI)
- lo_we  in  1  direct write LO (MTLO)
- hi_in  in  WIDTH  direct HI write data
- lo_in  in  WIDTH  direct LO write data
- busy  out  1  engine in CALC
- done  out  1  one-cycle pulse: result written to HI/LO
- hi_out  out  WIDTH  HI read data
- lo_out  out  WIDTH  LO read data

## Operation
- States: IDLE, CALC. Counter cnt of width clog2(WIDTH)+1.
- IDLE and start=1: latch op, |src_a|, |src_b| (abs only for signed ops), sign flags; cnt<=0; go CALC. In IDLE, start=0 is a no-op.
- start while in CALC is ignored; the caller must hold or re-issue it.
- CALC multiply: radix-2 shift-add on an unsigned 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC divide: radix-2 restoring division, one quotient bit per cycle.
- CALC lasts exactly WIDTH cycles. On the final edge, the sign-corrected result is written, state goes to IDLE and done is set for one cycle.
- Multiply result: {HI,LO} = product. Signed product is negated if sign_a^sign_b.
- Divide result: LO = quotient, HI = remainder. Signed quotient is negated if sign_a^sign_b; the remainder takes the sign of the dividend.
- Divide by zero, any div op: HI=src_a, LO=all ones. The latency is unchanged.
- Signed overflow (min / -1): LO=min (0x80000000 at WIDTH=32), HI=0.
- Direct writes: hi_we/lo_we update HI/LO independently in any state.
- Engine writeback and a direct write on the same edge: the engine wins for both HI and LO.
- flush=1 in CALC: return to IDLE at the next edge. HI/LO are unchanged, done stays 0, busy is 0 next cycle.
- flush=1 in IDLE has no effect.
- flush and start together in IDLE: flush wins and the start is dropped.
- rst has priority over everything: HI=0, LO=0, state=IDLE, cnt=0, busy=0, done=0. Reset mid-CALC discards the operation.

## Timing
- The start edge ends cycle 0. busy=1 in cycles 1..WIDTH, registered from state.
- Writeback happens at the end of cycle WIDTH. done=1 and the new hi_out/lo_out are visible in cycle WIDTH+1.
- A new start is accepted in cycle WIDTH+1, giving back-to-back throughput of WIDTH+1 cycles.
- A direct write issued in cycle n is visible on hi_out/lo_out in cycle n+1; with bypass enabled (see Configuration) it is visible in cycle n.
- busy and done are registered with no combinational path from inputs. hi_out/lo_out are registered unless bypass is enabled.

## Configuration
- HILO_BYPASS_EN defined: hi_out = hi_we ? hi_in : HI and lo_out = lo_we ? lo_in : LO. This is combinational forwarding of direct writes, so MFHI right after MTHI needs no stall. Engine results are never bypassed.
- HILO_BYPASS_EN undefined: hi_out/lo_out come straight from the registers, and the direct-write read latency is 1 cycle.

## Test plan
- Reset: drive rst for 2 cycles with busy traffic.
  - Required: hi_out=lo_out=0, busy=0, done=0.
- MULT, WIDTH=32: a=0xFFFFFFFE (-2), b=3.
  - Required: busy for 32 cycles; done in cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Divides:
  - DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
  - DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Flush: start MULTU 5*5 with HI/LO preloaded to 0x11/0x22, then flush in cycle 10.
  - Required: busy=0 in cycle 11, no done, HI=0x11, LO=0x22.
- Collision: MTHI 0xAAAA issued in the writeback cycle of MULTU 2*3.
  - Required: HI=0, LO=6.
  - Required: an MTLO 0x55 in cycle 5 of CALC is overwritten by the result.
- Bypass:
  - With HILO_BYPASS_EN: hi_we=1, hi_in=0x1234 -> hi_out=0x1234 in the same cycle.
  - Without it: the old value shows that cycle and 0x1234 the next.
